pio_cmd_engine: RTL and testbench
=================================

# pio_cmd_engine

Command execution stage directly downstream of the HPS-facing 32-bit parallel I/O ports. It consumes the address, data and control words that software writes through those ports, and turns each software "start" into one or more memory transactions on a simple waited memory port. Single write, block fill and single read are supported. It returns busy, done and error status, plus read data, as 32-bit words that feed the input side of status PIOs.

## Interface
Parameters:
- MEM_AW, 17, memory address width; the address is taken from addr_word[MEM_AW-1:0].
- MEM_DW, 32, memory data width (≤32); the write data is taken from data_word[MEM_DW-1:0].
- RD_LAT, 1, fixed number of cycles from read acceptance to valid mem_rdata (1..7).

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  clock; all ports are synchronous to clk.
- reset_n  in  1  asynchronous active-low reset.
- addr_word  in  32  target address, from the address PIO out_port.
- data_word  in  32  write/fill data, from the data PIO out_port.
- ctrl_word  in  32  [0] start, [2:1] opcode (00 NOP, 01 WRITE, 10 FILL, 11 READ), [31:16] fill count.
- mem_addr  out  MEM_AW  memory address.
- mem_wdata  out  MEM_DW  memory write data.
- mem_we  out  1  write request.
- mem_re  out  1  read request.
- mem_waitrequest  in  1  stall; a request is accepted on an edge where the request is high and mem_waitrequest=0.
- mem_rdata  in  MEM_DW  read data, valid RD_LAT cycles after read acceptance.
- status_word  out  32  [0] busy, [1] done, [2] err_zero_count, [3] overrun, [15:4] 0, [31:16] remaining fill count.
- rdata_word  out  32  last read data, zero-extended.

## Operation
Start detection:
- start_q is a registered copy of ctrl_word[0].
- start_edge = ctrl_word[0] & ~start_q, i.e. the rising edge of start.

Accepting a start:
- A start_edge in IDLE is accepted.
- On acceptance, the block captures addr, data, opcode and count, clears done/err/overrun, and sets busy.
- A start_edge when not in IDLE is dropped and sets overrun. Overrun is sticky until the next accepted start.

States:
- IDLE: busy=0.
  - Accepted start with NOP → stays IDLE; done=1.
  - WRITE → WR.
  - FILL with count≠0 → WR; remaining=count.
  - FILL with count=0 → IDLE; done=1, err_zero_count=1; no memory access.
  - READ → RD.
- WR: mem_we=1, holding mem_addr and mem_wdata stable while stalled.
  - On acceptance: addr ← addr+1, wrapping modulo 2^MEM_AW; remaining ← remaining-1.
  - Exit to IDLE with done=1 when the accepted write is the last one (WRITE, or FILL with remaining=1).
- RD: mem_re=1 until accepted, then → RWAIT.
- RWAIT: count RD_LAT cycles from acceptance, then capture mem_rdata into rdata_word → IDLE; done=1.

Flag behaviour:
- mem_we and mem_re are never high together.
- done is sticky until the next accepted start.
- status_word[31:16] shows the live remaining count during FILL and 0 otherwise.

## Timing
- Reset values: every output is 0, including mem_we, mem_re, status_word and rdata_word. State is IDLE and start_q=0.
- Reset asserted mid-operation aborts the operation immediately. The aborted operation does not resume after reset.
- A start_edge sampled at edge E0 gives busy=1 and the first mem_we or mem_re high after E0.
- With no stalls, a FILL of N words issues one write per cycle. busy drops after edge E0+N.
- A start held high does not re-trigger; software must drop it and raise it again.
- start_edge coinciding with the final write acceptance counts as not-IDLE: it is dropped and sets overrun.

## Configuration
- CMD_SYNC_EN defined: ctrl_word[0] passes through a two-flop synchronizer before start_q and edge detection. This allows the PIO block to sit on an unrelated clock. Start-to-request latency grows by 2 cycles. addr_word, data_word and ctrl_word[31:1] must then be stable before start rises.
- CMD_SYNC_EN undefined: ctrl_word[0] is used directly; the PIO block shares clk.

## Test plan
- WRITE: addr 0x00010, data 0xDEADBEEF, ctrl 0x3 → one mem_we with addr 0x10 / data 0xDEADBEEF → done=1, busy=0, status_word=0x2.
- FILL with stalls: addr 0x1FFFE, count 4, waitrequest high 2 cycles on the 2nd write → writes to 0x1FFFE, 0x1FFFF, 0x00000, 0x00001, each held while stalled; remaining field counts 4→0.
- FILL count 0: ctrl 0x0000_0005 → no mem_we; status_word=0x6.
- READ with RD_LAT=3: mem_rdata 0x12345678 valid 3 cycles after acceptance → rdata_word=0x12345678, done=1.
- Overrun: second start edge during a 16-word FILL → the fill completes normally; status_word bit3=1; the next accepted start clears it.
- Reset mid-FILL: reset_n low at the 3rd write → mem_we=0 immediately, all outputs 0; no writes after release until a new start.

Source files
------------

// File: rtl/pio_cmd_engine.sv
// pio_cmd_engine: executes software PIO commands (write, block fill, read) on a waited memory port.
//
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   addr_word           target address from the address PIO (low MEM_AW bits used)
//   data_word           write/fill data from the data PIO (low MEM_DW bits used)
//   ctrl_word           [0] start, [2:1] opcode (00 NOP, 01 WRITE, 10 FILL, 11 READ), [31:16] fill count
//   mem_addr/mem_wdata  memory address and write data, held stable while a request stalls
//   mem_we/mem_re       write/read request, accepted on an edge with mem_waitrequest low
//   mem_waitrequest     memory stall
//   mem_rdata           read data, valid RD_LAT cycles after read acceptance
//   status_word         [0] busy, [1] done, [2] err_zero_count, [3] overrun, [31:16] remaining fill count
//   rdata_word          last read data, zero-extended
//
// Build option: define CMD_SYNC_EN to pass ctrl_word[0] through a two-flop synchronizer
// when the PIO block runs on an unrelated clock (adds 2 cycles of start latency).
module pio_cmd_engine #(
    parameter int MEM_AW = 17,
    parameter int MEM_DW = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       addr_word,
    input  logic [31:0]       data_word,
    input  logic [31:0]       ctrl_word,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic              mem_waitrequest,
    input  logic [MEM_DW-1:0] mem_rdata,
    output logic [31:0]       status_word,
    output logic [31:0]       rdata_word
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR    = 2'd1;
    localparam logic [1:0] S_RD    = 2'd2;
    localparam logic [1:0] S_RWAIT = 2'd3;

    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_FILL  = 2'd2;
    localparam logic [1:0] OP_READ  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [MEM_DW-1:0] wdata_q, wdata_d;
    logic [15:0]       rem_q, rem_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ovr_q, ovr_d;
    logic [MEM_DW-1:0] rdata_q, rdata_d;
    logic              start_q;
    logic              start_in;
    logic              start_edge;
    logic              idle;
    logic              unused_bits;

    // Only slices of the PIO words are meaningful; the rest is intentionally ignored.
    assign unused_bits = ^{addr_word, data_word, ctrl_word};

`ifdef CMD_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], ctrl_word[0]};
    end

    assign start_in = sync_q[1];
`else
    assign start_in = ctrl_word[0];
`endif

    assign start_edge = start_in & ~start_q;
    assign idle       = (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        ovr_d   = ovr_q;
        rdata_d = rdata_q;
        // A start while a command is in flight (including on its final acceptance edge) is dropped.
        if (start_edge && !idle) ovr_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    op_d    = ctrl_word[2:1];
                    addr_d  = addr_word[MEM_AW-1:0];
                    wdata_d = data_word[MEM_DW-1:0];
                    rem_d   = 16'd0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    ovr_d   = 1'b0;
                    case (ctrl_word[2:1])
                        OP_NOP:   done_d = 1'b1;
                        OP_WRITE: state_d = S_WR;
                        OP_FILL: begin
                            if (ctrl_word[31:16] == 16'd0) begin
                                done_d = 1'b1;
                                err_d  = 1'b1;
                            end else begin
                                state_d = S_WR;
                                rem_d   = ctrl_word[31:16];
                            end
                        end
                        OP_READ:  state_d = S_RD;
                    endcase
                end
            end
            S_WR: begin
                if (!mem_waitrequest) begin
                    addr_d = addr_q + MEM_AW'(1);
                    if (op_q == OP_FILL) rem_d = rem_q - 16'd1;
                    if (op_q != OP_FILL || rem_q == 16'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (!mem_waitrequest) begin
                    state_d = S_RWAIT;
                    cnt_d   = 3'(RD_LAT - 1);
                end
            end
            S_RWAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = mem_rdata;
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rem_q   <= 16'd0;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
            rdata_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            rdata_q <= rdata_d;
            start_q <= start_in;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_we      = (state_q == S_WR);
    assign mem_re      = (state_q == S_RD);
    // rem_q is only non-zero while a FILL is in progress.
    assign status_word = {rem_q, 12'd0, ovr_q, err_q, done_q, ~idle};
    assign rdata_word  = 32'(rdata_q);

endmodule

// File: tb/tb_pio_cmd_engine.sv
// tb_pio_cmd_engine: directed self-checking bench for pio_cmd_engine (RD_LAT=3).
module tb_pio_cmd_engine;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] addr_word, data_word, ctrl_word;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, mem_re;
    logic        mem_waitrequest;
    logic [31:0] mem_rdata;
    logic [31:0] status_word, rdata_word;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [31:0] wa [64];
    logic [31:0] wd [64];
    logic        both_seen = 1'b0;
    logic [2:0]  rp;

    pio_cmd_engine #(.MEM_AW(17), .MEM_DW(32), .RD_LAT(3)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .addr_word(addr_word),
        .data_word(data_word),
        .ctrl_word(ctrl_word),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we(mem_we),
        .mem_re(mem_re),
        .mem_waitrequest(mem_waitrequest),
        .mem_rdata(mem_rdata),
        .status_word(status_word),
        .rdata_word(rdata_word)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we && !mem_waitrequest) begin
            wa[wr_cnt] <= 32'(mem_addr);
            wd[wr_cnt] <= mem_wdata;
            wr_cnt     <= wr_cnt + 1;
        end
        if (mem_we && mem_re) both_seen <= 1'b1;
    end

    // Read data is only valid in the single cycle three cycles after acceptance.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rp <= 3'b000;
        else          rp <= {rp[1:0], mem_re & ~mem_waitrequest};
    end
    assign mem_rdata = rp[2] ? 32'h1234_5678 : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] a, input logic [31:0] d, input logic [31:0] c);
        addr_word = a;
        data_word = d;
        ctrl_word = c;
        tick;
        ctrl_word[0] = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && status_word[0]; i++) tick;
        chk(tag, 32'(status_word[0]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] fill_addr [4];
        fill_addr = '{32'h1FFFE, 32'h1FFFF, 32'h00000, 32'h00001};
        reset_n = 1'b0;
        mem_waitrequest = 1'b0;
        addr_word = 0;
        data_word = 0;
        ctrl_word = 0;
        repeat (3) tick;
        chk("rst_status", status_word, 32'h0);
        chk("rst_rdata", rdata_word, 32'h0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_re", 32'(mem_re), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        reset_n = 1'b1;
        tick;

        go(32'h10, 32'hDEAD_BEEF, 32'h3);
        chk("w_busy", status_word, 32'h1);
        chk("w_we", 32'(mem_we), 32'd1);
        chk("w_addr", 32'(mem_addr), 32'h10);
        chk("w_data", mem_wdata, 32'hDEAD_BEEF);
        tick;
        chk("w_status", status_word, 32'h2);
        chk("w_we_off", 32'(mem_we), 32'd0);
        chk("w_cnt", 32'(wr_cnt), 32'd1);
        chk("w_log_a", wa[0], 32'h10);
        chk("w_log_d", wd[0], 32'hDEAD_BEEF);

        go(32'h1FFFE, 32'hA5A5_0001, 32'h0004_0005);
        chk("f_st0", status_word, 32'h0004_0001);
        chk("f_a0", 32'(mem_addr), 32'h1FFFE);
        tick;
        chk("f_a1", 32'(mem_addr), 32'h1FFFF);
        chk("f_st1", status_word, 32'h0003_0001);
        mem_waitrequest = 1'b1;
        tick;
        chk("f_hold_a", 32'(mem_addr), 32'h1FFFF);
        chk("f_hold_we", 32'(mem_we), 32'd1);
        tick;
        chk("f_hold_st", status_word, 32'h0003_0001);
        chk("f_hold_d", mem_wdata, 32'hA5A5_0001);
        mem_waitrequest = 1'b0;
        tick;
        chk("f_a2", 32'(mem_addr), 32'h0);
        chk("f_st2", status_word, 32'h0002_0001);
        tick;
        chk("f_a3", 32'(mem_addr), 32'h1);
        chk("f_st3", status_word, 32'h0001_0001);
        tick;
        chk("f_done", status_word, 32'h2);
        chk("f_cnt", 32'(wr_cnt), 32'd5);
        for (int i = 0; i < 4; i++) chk($sformatf("f_log_a%0d", i), wa[1+i], fill_addr[i]);
        chk("f_log_d", wd[4], 32'hA5A5_0001);

        go(32'h50, 32'h0, 32'h0000_0005);
        chk("z_st", status_word, 32'h6);
        chk("z_we", 32'(mem_we), 32'd0);
        tick;
        chk("z_cnt", 32'(wr_cnt), 32'd5);

        go(32'h123, 32'h0, 32'h7);
        chk("r_re", 32'(mem_re), 32'd1);
        chk("r_st", status_word, 32'h1);
        mem_waitrequest = 1'b1;
        tick;
        chk("r_hold", 32'(mem_re), 32'd1);
        mem_waitrequest = 1'b0;
        tick;
        chk("r_re_off", 32'(mem_re), 32'd0);
        tick;
        tick;
        chk("r_early", rdata_word, 32'h0);
        chk("r_busy", status_word, 32'h1);
        tick;
        chk("r_data", rdata_word, 32'h1234_5678);
        chk("r_done", status_word, 32'h2);

        go(32'h100, 32'h55, 32'h0010_0005);
        repeat (3) tick;
        ctrl_word = 32'h0010_0005;
        tick;
        chk("o_st", status_word, 32'h000C_0009);
        ctrl_word = 32'h0010_0004;
        wait_idle("o_idle", 40);
        chk("o_done", status_word, 32'hA);
        chk("o_cnt", 32'(wr_cnt), 32'd21);
        chk("o_last", wa[20], 32'h10F);
        go(32'h200, 32'h77, 32'h3);
        chk("o_clr", status_word, 32'h1);
        tick;
        chk("o_clr_done", status_word, 32'h2);

        go(32'h300, 32'h9, 32'h0002_0005);
        tick;
        ctrl_word = 32'h0002_0005;
        tick;
        chk("c_st", status_word, 32'hA);
        repeat (2) tick;
        chk("c_held", status_word, 32'hA);
        chk("c_cnt", 32'(wr_cnt), 32'd24);
        ctrl_word = 32'h0002_0004;
        tick;

        go(32'h400, 32'h11, 32'h0008_0005);
        tick;
        tick;
        chk("m_we_pre", 32'(mem_we), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("m_we", 32'(mem_we), 32'd0);
        chk("m_st", status_word, 32'h0);
        chk("m_addr", 32'(mem_addr), 32'h0);
        chk("m_rdata", rdata_word, 32'h0);
        repeat (2) tick;
        reset_n = 1'b1;
        repeat (4) tick;
        chk("m_idle", status_word, 32'h0);
        chk("m_we_post", 32'(mem_we), 32'd0);
        chk("m_cnt", 32'(wr_cnt), 32'd26);

        chk("excl", 32'(both_seen), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
